present_decrypt: RTL and testbench

Iterative PRESENT-80 block decryptor. It is the inverse of the team's PRESENT encryption core.
- Takes a 64-bit ciphertext and an 80-bit key, and returns the 64-bit plaintext.
- Derives the final round key on the fly with a forward key-schedule pass, then runs the 31 inverse rounds while un-rolling the key schedule backwards.
- Sits beside the encrypt core in the crypto datapath and shares its S-box/P-layer definitions (inverse forms).

---
 rtl/present_decrypt.sv | 158 +++++++++++++++
 tb/tb_present_decrypt.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: a forward key-schedule pass derives K32, then 31 inverse
// rounds run while the schedule is unwound back to the original key.
module present_decrypt #(
  parameter int unsigned SIZE       = 64,
  parameter int unsigned KEY_SIZE   = 80,
  parameter int unsigned NUM_ROUNDS = 31
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [KEY_SIZE-1:0] Key,
  input  logic [SIZE-1:0]     Ciphertext,
  output logic [SIZE-1:0]     Plaintext,
  output logic                Busy,
  output logic                Done
);

  typedef enum logic [1:0] {StIdle, StKeygen, StDecrypt, StFinish} state_e;

  localparam logic [4:0] LastRound = 5'(NUM_ROUNDS);

  state_e              state_q, state_d;
  logic [4:0]          rc_q, rc_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [SIZE-1:0]     st_q, st_d;
  logic [SIZE-1:0]     plaintext_q, plaintext_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'h5;  4'h1: r = 4'hE;  4'h2: r = 4'hF;  4'h3: r = 4'h8;
      4'h4: r = 4'hC;  4'h5: r = 4'h1;  4'h6: r = 4'h2;  4'h7: r = 4'hD;
      4'h8: r = 4'hB;  4'h9: r = 4'h4;  4'hA: r = 4'h6;  4'hB: r = 4'h3;
      4'hC: r = 4'h0;  4'hD: r = 4'h7;  4'hE: r = 4'h9;  default: r = 4'hA;
    endcase
    return r;
  endfunction

  // Bit P(i) of the permuted word returns to position i.
  function automatic logic [SIZE-1:0] inv_p(input logic [SIZE-1:0] x);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE - 1; i++) begin
      r[i] = x[(16 * i) % (SIZE - 1)];
    end
    r[SIZE-1] = x[SIZE-1];
    return r;
  endfunction

  function automatic logic [SIZE-1:0] inv_s_layer(input logic [SIZE-1:0] x);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE / 4; i++) begin
      r[4*i +: 4] = sbox_inv(x[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [KEY_SIZE-1:0] key_fwd(input logic [KEY_SIZE-1:0] k,
                                                  input logic [4:0] rc);
    logic [KEY_SIZE-1:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic [KEY_SIZE-1:0] key_inv(input logic [KEY_SIZE-1:0] k,
                                                  input logic [4:0] rc);
    logic [KEY_SIZE-1:0] r;
    r = k;
    r[19:15] = r[19:15] ^ rc;
    r[79:76] = sbox_inv(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    key_d       = key_q;
    st_d        = st_q;
    plaintext_d = plaintext_q;
    done_d      = 1'b0;
    // Lags the state by one edge so Busy falls together with Done.
    busy_d      = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (Start) begin
          key_d   = Key;
          st_d    = Ciphertext;
          rc_d    = 5'd1;
          state_d = StKeygen;
        end
      end
      StKeygen: begin
        key_d = key_fwd(key_q, rc_q);
        if (rc_q == LastRound) begin
          state_d = StDecrypt;
        end else begin
          rc_d = rc_q + 5'd1;
        end
      end
      StDecrypt: begin
        st_d  = inv_s_layer(inv_p(st_q ^ key_q[KEY_SIZE-1 -: SIZE]));
        key_d = key_inv(key_q, rc_q);
        rc_d  = rc_q - 5'd1;
        if (rc_q == 5'd1) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        plaintext_d = st_q ^ key_q[KEY_SIZE-1 -: SIZE];
        done_d      = 1'b1;
        rc_d        = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      rc_q        <= '0;
      key_q       <= '0;
      st_q        <= '0;
      plaintext_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      key_q       <= key_d;
      st_q        <= st_d;
      plaintext_q <= plaintext_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Plaintext = plaintext_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_present_decrypt.sv
// Scoreboard bench for present_decrypt: drivers queue expected plaintexts, a monitor checks
// each Done pulse against the queue. References come from a round-key-array PRESENT model.
module tb_present_decrypt;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [79:0] Key;
  logic [63:0] Ciphertext;
  logic [63:0] Plaintext;
  logic        Busy;
  logic        Done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] exp_q[$];

  localparam logic [3:0] SB  [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] ISB [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  present_decrypt dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Key        (Key),
    .Ciphertext (Ciphertext),
    .Plaintext  (Plaintext),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  function automatic int perm(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction

  function automatic logic [79:0] ks_next(input logic [79:0] k, input int r);
    logic [79:0] n;
    n = {k[18:0], k[79:19]};
    n[79:76] = SB[n[79:76]];
    n[19:15] = n[19:15] ^ 5'(r);
    return n;
  endfunction

  function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = SB[s[4*j +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[perm(i)] = s[i];
      s = t;
      k = ks_next(k, r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] model_dec(input logic [63:0] ct, input logic [79:0] key);
    logic [79:0] rk [33];
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k;
      if (r < 32) k = ks_next(k, r);
    end
    s = ct ^ rk[32][79:16];
    for (int r = 31; r >= 1; r--) begin
      t = '0;
      for (int i = 0; i < 64; i++) t[i] = s[perm(i)];
      for (int j = 0; j < 16; j++) t[4*j +: 4] = ISB[t[4*j +: 4]];
      s = t ^ rk[r][79:16];
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every Done pulse must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (Reset === 1'b0 && Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got Done=1 expected no pending result");
      end else begin
        chk("plaintext", Plaintext, exp_q.pop_front());
      end
    end
  end

  // Issues one block; returns just after the edge that raises Done (or after the bound).
  task automatic run(input logic [79:0] k, input logic [63:0] c, input logic [63:0] e,
                     input bit hold, output int lat);
    logic [95:0] r96;
    exp_q.push_back(e);
    Key = k;
    Ciphertext = c;
    Start = 1'b1;
    @(posedge Clock); #1;
    if (!hold) Start = 1'b0;
    lat = 0;
    chk("busy_after_accept", 64'(Busy), 64'd0);
    while (Done !== 1'b1 && lat < 100) begin
      if (hold) begin
        r96 = {$urandom, $urandom, $urandom};
        Key = r96[79:0];
        Ciphertext = r96[95:32];
      end
      @(posedge Clock); #1;
      lat++;
      if (lat == 1) chk("busy_edge1", 64'(Busy), 64'd1);
    end
    Start = 1'b0;
    chk("latency", 64'(lat), 64'd63);
    chk("busy_at_done", 64'(Busy), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dones;
    int last_done;
    logic [95:0] r96;
    logic [79:0] rk;
    logic [63:0] rp, rc;

    Reset = 1'b1;
    Start = 1'b0;
    Key = '0;
    Ciphertext = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_plaintext", Plaintext, 64'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // 1: zero key vector, then idle behaviour after Done
    run(80'h0, 64'h5579C1387B228445, 64'h0, 1'b0, lat);
    @(posedge Clock); #1;
    chk("t1_busy_after", 64'(Busy), 64'd0);
    chk("t1_done_after", 64'(Done), 64'd0);
    chk("t1_plaintext_held", Plaintext, 64'h0);

    // 2: back-to-back, Start the cycle after Done
    run({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0, 1'b0, lat);
    run(80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 1'b0, lat);
    @(posedge Clock); #1;

    // 3: Start held and inputs toggled throughout the run
    run({80{1'b1}}, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 1'b1, lat);
    dones = 0;
    repeat (70) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) dones++;
    end
    chk("t3_no_second_run", 64'(dones), 64'd0);
    chk("t3_idle_busy", 64'(Busy), 64'd0);
    chk("t3_plaintext_held", Plaintext, 64'hFFFFFFFFFFFFFFFF);

    // 4: reset during the decrypt phase aborts silently
    Key = 80'h0;
    Ciphertext = 64'h5579C1387B228445;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (40) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("t4_busy", 64'(Busy), 64'd0);
    chk("t4_done", 64'(Done), 64'd0);
    chk("t4_plaintext", Plaintext, 64'd0);
    dones = 0;
    repeat (80) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) dones++;
    end
    chk("t4_no_done_after_abort", 64'(dones), 64'd0);
    run(80'h0, 64'h5579C1387B228445, 64'h0, 1'b0, lat);
    @(posedge Clock); #1;

    // 5: loopback through the encrypt model, back-to-back, Done spacing 64
    last_done = 0;
    for (int i = 0; i < 8; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      rk = r96[79:0];
      rp = {$urandom, $urandom};
      run(rk, model_enc(rp, rk), rp, 1'b0, lat);
      if (i > 0) chk("t5_done_spacing", 64'(cyc - last_done), 64'd64);
      last_done = cyc;
    end
    @(posedge Clock); #1;

    // random ciphertexts against the decrypt model
    for (int i = 0; i < 4; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      rk = r96[79:0];
      rc = {$urandom, $urandom};
      run(rk, rc, model_dec(rc, rk), 1'b0, lat);
    end

    repeat (3) @(posedge Clock);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
